fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 178 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Instruction fetch / decode / execute / memory sequencer. Fetches
//            halfword instructions from a 1024-word memory, hands them to the
//            decoder, waits for the execute unit, performs an optional data
//            access and retires (pc and instruction count update).
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer (
   input  logic        clock_i,
   input  logic        reset_n_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [9:0]  mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i,
   output logic [15:0] instr_o,
   output logic        instr_valid_o,
   input  logic        exec_done_i,
   input  logic        needs_mem_i,
   input  logic        mem_wr_i,
   input  logic [9:0]  data_addr_i,
   input  logic [31:0] data_wdata_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic        halt_req_i,
   output logic [31:0] load_data_o,
   output logic        load_valid_o,
   output logic [31:0] pc_o,
   output logic        halted_o,
   output logic [31:0] instr_count_o
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_HALT   = 3'd4;

   logic [2:0]  state_q,       state_d;
   logic        run_q,         run_d;        // low only in the cycle right after reset
   logic [31:0] pc_q,          pc_d;
   logic [15:0] instr_q,       instr_d;
   logic [31:0] count_q,       count_d;
   logic [31:0] load_data_q,   load_data_d;
   logic        load_valid_q,  load_valid_d;
   logic        mem_we_q,      mem_we_d;
   logic [9:0]  mem_addr_q,    mem_addr_d;
   logic [31:0] mem_wdata_q,   mem_wdata_d;
   logic        br_taken_q,    br_taken_d;   // branch decision held across MEM
   logic [31:0] br_target_q,   br_target_d;

   logic        retire;
   logic        ret_taken;
   logic [31:0] ret_target;

   // Next-state logic: state transitions, access latching and retirement
   always_comb begin
      state_d      = state_q;
      run_d        = 1'b1;
      pc_d         = pc_q;
      instr_d      = instr_q;
      count_d      = count_q;
      load_data_d  = load_data_q;
      load_valid_d = 1'b0;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      br_taken_d   = br_taken_q;
      br_target_d  = br_target_q;
      retire       = 1'b0;
      ret_taken    = branch_taken_i;
      ret_target   = branch_target_i;

      case (state_q)
         S_FETCH: begin
            // The request is not presented during the reset-recovery cycle,
            // so an ack there is not ours.
            if (run_q && mem_ack_i) begin
               instr_d = pc_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (exec_done_i) begin
               if (halt_req_i) begin
                  state_d = S_HALT;
               end else if (needs_mem_i) begin
                  state_d     = S_MEM;
                  mem_we_d    = mem_wr_i;
                  mem_addr_d  = data_addr_i;
                  mem_wdata_d = data_wdata_i;
                  br_taken_d  = branch_taken_i;
                  br_target_d = branch_target_i;
               end else begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
            end
         end
         S_MEM: begin
            ret_taken  = br_taken_q;
            ret_target = br_target_q;
            if (mem_ack_i) begin
               retire  = 1'b1;
               state_d = S_FETCH;
               if (!mem_we_q) begin
                  load_data_d  = mem_rdata_i;
                  load_valid_d = 1'b1;
               end
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      if (retire) begin
         pc_d    = ret_taken ? (ret_target & ~32'd1) : pc_q + 32'd2;
         count_d = count_q + 32'd1;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         state_q      <= S_FETCH;
         run_q        <= 1'b0;
         pc_q         <= 32'd0;
         instr_q      <= 16'd0;
         count_q      <= 32'd0;
         load_data_q  <= 32'd0;
         load_valid_q <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 10'd0;
         mem_wdata_q  <= 32'd0;
         br_taken_q   <= 1'b0;
         br_target_q  <= 32'd0;
      end else begin
         state_q      <= state_d;
         run_q        <= run_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         count_q      <= count_d;
         load_data_q  <= load_data_d;
         load_valid_q <= load_valid_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         br_taken_q   <= br_taken_d;
         br_target_q  <= br_target_d;
      end
   end

   // Outputs are decoded from registered state only
   assign mem_req_o     = run_q && ((state_q == S_FETCH) || (state_q == S_MEM));
   assign mem_we_o      = (state_q == S_MEM) && mem_we_q;
   assign mem_addr_o    = (state_q == S_MEM) ? mem_addr_q : pc_q[11:2];
   assign mem_wdata_o   = mem_wdata_q;
   assign instr_o       = instr_q;
   assign instr_valid_o = (state_q == S_DECODE);
   assign load_data_o   = load_data_q;
   assign load_valid_o  = load_valid_q;
   assign pc_o          = pc_q;
   assign halted_o      = (state_q == S_HALT);
   assign instr_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Randomised scoreboard bench for fetch_sequencer with a memory
//            responder, an instruction-level reference model and a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        mem_req, mem_we, mem_ack;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic [15:0] instr;
   logic        instr_valid, exec_done, needs_mem, mem_wr, branch_taken, halt_req;
   logic [9:0]  data_addr;
   logic [31:0] data_wdata, branch_target;
   logic [31:0] load_data, pc, instr_count;
   logic        load_valid, halted;

   fetch_sequencer dut (
      .clock_i(clock), .reset_n_i(reset_n),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
      .instr_o(instr), .instr_valid_o(instr_valid), .exec_done_i(exec_done),
      .needs_mem_i(needs_mem), .mem_wr_i(mem_wr), .data_addr_i(data_addr),
      .data_wdata_i(data_wdata), .branch_taken_i(branch_taken),
      .branch_target_i(branch_target), .halt_req_i(halt_req),
      .load_data_o(load_data), .load_valid_o(load_valid), .pc_o(pc),
      .halted_o(halted), .instr_count_o(instr_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] pc;
      logic [15:0] instr;
      logic [31:0] cnt;
   } exp_instr_t;

   exp_instr_t  q_instr[$];
   logic [31:0] q_load[$];
   logic [41:0] q_wr[$];

   logic [31:0] mem     [0:1023];   // memory seen by the DUT
   logic [31:0] ref_mem [0:1023];   // reference model's view
   logic [31:0] m_pc, m_cnt;
   int          checks = 0;
   int          errors = 0;
   int          fixed_delay = 0;
   bit          mon_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] half_at(input logic [31:0] a);
      logic [31:0] w;
      w = ref_mem[a[11:2]];
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   task automatic push_next();
      exp_instr_t e;
      e.pc = m_pc; e.instr = half_at(m_pc); e.cnt = m_cnt;
      q_instr.push_back(e);
   endtask

   // Memory responder: random (or fixed) ack latency, single-cycle ack
   initial begin
      int wait_left;
      wait_left = -1;
      mem_ack = 1'b0;
      mem_rdata = 32'd0;
      forever begin
         @(posedge clock); #1;
         if (mem_req) begin
            if (wait_left < 0)
               wait_left = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
            if (wait_left == 0) begin
               mem_ack = 1'b1;
               if (mem_we) mem[mem_addr] = mem_wdata;
               else        mem_rdata = mem[mem_addr];
               wait_left = -1;
            end else begin
               mem_ack = 1'b0;
               mem_rdata = $urandom;
               wait_left--;
            end
         end else begin
            mem_ack = 1'b0;
            wait_left = -1;
         end
      end
   end

   // Monitor: pops expected responses whenever the DUT presents one
   initial begin
      logic        p_req, p_ack, p_we;
      logic [9:0]  p_addr;
      logic [31:0] p_wdata;
      exp_instr_t  e;
      logic [31:0] ld;
      logic [41:0] wr;
      p_req = 1'b0; p_ack = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
      forever begin
         @(negedge clock);
         if (mon_en) begin
            if (instr_valid) begin
               chk("req_in_decode", {63'd0, mem_req}, 64'd0);
               if (q_instr.size() == 0) chk("unexpected_instr_valid", 64'd1, 64'd0);
               else begin
                  e = q_instr.pop_front();
                  chk("instr", {48'd0, instr}, {48'd0, e.instr});
                  chk("pc", {32'd0, pc}, {32'd0, e.pc});
                  chk("instr_count", {32'd0, instr_count}, {32'd0, e.cnt});
               end
            end
            if (load_valid) begin
               if (q_load.size() == 0) chk("unexpected_load_valid", 64'd1, 64'd0);
               else begin
                  ld = q_load.pop_front();
                  chk("load_data", {32'd0, load_data}, {32'd0, ld});
               end
            end
            if (mem_req && mem_we && mem_ack) begin
               if (q_wr.size() == 0) chk("unexpected_store", 64'd1, 64'd0);
               else begin
                  wr = q_wr.pop_front();
                  chk("store", {22'd0, mem_addr, mem_wdata}, {22'd0, wr});
               end
            end
            if (halted) chk("req_in_halt", {63'd0, mem_req}, 64'd0);
            if (p_req && !p_ack && mem_req)
               chk("held_request", {21'd0, mem_we, mem_addr, mem_wdata},
                   {21'd0, p_we, p_addr, p_wdata});
         end
         p_req = mem_req; p_ack = mem_ack; p_we = mem_we;
         p_addr = mem_addr; p_wdata = mem_wdata;
      end
   end

   // One instruction: wait for decode, then answer exec_done per mode.
   // Modes: 0 random, 1 plain, 2 branch 0x105, 3 branch 0xFFFFFFFE,
   //        4 load 0x3FF, 5 store, 6 halt with needs_mem, 7 random-address load
   task automatic do_instr(input int mode);
      bit seen;
      int d;
      logic [31:0] tgt;
      seen = 1'b0;
      for (int b = 0; b < 60 && !seen; b++) begin
         @(posedge clock); #1;
         exec_done = 1'b0;
         if (instr_valid) seen = 1'b1;
      end
      if (!seen) begin
         chk("instr_valid_timeout", 64'd1, 64'd0);
         return;
      end
      d = (mode == 0) ? int'($urandom_range(0, 2)) : 0;
      @(posedge clock); #1;
      repeat (d) begin @(posedge clock); #1; end
      halt_req = 1'b0; needs_mem = 1'b0; mem_wr = 1'b0; branch_taken = 1'b0;
      branch_target = $urandom; data_addr = 10'($urandom); data_wdata = $urandom;
      case (mode)
         0: begin
            branch_taken = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) branch_target = 32'hFFFF_FFFE;
            needs_mem = $urandom_range(0, 1) == 1;
            mem_wr = $urandom_range(0, 1) == 1;
         end
         2: begin branch_taken = 1'b1; branch_target = 32'h0000_0105; end
         3: begin branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE; end
         4: begin needs_mem = 1'b1; data_addr = 10'h3FF; end
         5: begin needs_mem = 1'b1; mem_wr = 1'b1; end
         6: begin halt_req = 1'b1; needs_mem = 1'b1; end
         7: begin needs_mem = 1'b1; end
         default: ;
      endcase
      exec_done = 1'b1;
      if (!halt_req) begin
         if (needs_mem && !mem_wr) q_load.push_back(ref_mem[data_addr]);
         if (needs_mem && mem_wr) begin
            q_wr.push_back({data_addr, data_wdata});
            ref_mem[data_addr] = data_wdata;
         end
         tgt = branch_target;
         tgt[0] = 1'b0;
         m_pc  = branch_taken ? tgt : m_pc + 32'd2;
         m_cnt = m_cnt + 32'd1;
         push_next();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; exec_done = 1'b0; needs_mem = 1'b0; mem_wr = 1'b0;
      data_addr = '0; data_wdata = '0; branch_taken = 1'b0; branch_target = '0;
      halt_req = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      mem[0] = 32'h3001_2002;
      mem[10'h3FF] = 32'hDEAD_BEEF;
      for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];

      // Reset values
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
      chk("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
      chk("rst_load_valid", {63'd0, load_valid}, 64'd0);
      chk("rst_halted", {63'd0, halted}, 64'd0);
      chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
      chk("rst_pc", {32'd0, pc}, 64'd0);
      chk("rst_instr", {48'd0, instr}, 64'd0);
      chk("rst_count", {32'd0, instr_count}, 64'd0);
      chk("rst_load_data", {32'd0, load_data}, 64'd0);

      @(posedge clock); #1;
      reset_n = 1'b1;
      m_pc = 32'd0; m_cnt = 32'd0;
      push_next();
      mon_en = 1'b1;
      @(negedge clock);
      chk("req_low_before_sampled", {63'd0, mem_req}, 64'd0);
      @(negedge clock);
      chk("first_req", {53'd0, mem_req, mem_addr}, {53'd0, 1'b1, 10'd0});

      // Directed sequence, then randomised traffic
      fixed_delay = 0;
      do_instr(1); do_instr(1); do_instr(2); do_instr(3); do_instr(1);
      do_instr(4); do_instr(5);
      fixed_delay = 3;
      do_instr(1);
      fixed_delay = -1;
      for (int n = 0; n < 150; n++) do_instr(0);
      do_instr(6);

      // Halt is absorbing
      repeat (4) begin
         @(posedge clock); #1;
         exec_done = 1'b0; halt_req = 1'b0; needs_mem = 1'b0;
         @(negedge clock);
         chk("halted", {62'd0, halted, mem_req}, {62'd0, 2'b10});
      end
      chk("halt_count", {32'd0, instr_count}, {32'd0, m_cnt});
      chk("queues_drained", {32'd0, 10'(q_instr.size()), 10'(q_load.size()), 12'(q_wr.size())}, 64'd0);

      // One-cycle reset out of HALT
      @(posedge clock); #1; reset_n = 1'b0;
      @(posedge clock); #1; reset_n = 1'b1;
      m_pc = 32'd0; m_cnt = 32'd0;
      push_next();
      @(negedge clock);
      chk("halt_reset", {30'd0, halted, mem_req, pc}, 64'd0);
      @(negedge clock);
      chk("refetch_req", {53'd0, mem_req, mem_addr}, {53'd0, 1'b1, 10'd0});

      // Reset during a load with ack in the same cycle
      fixed_delay = 0;
      do_instr(1); do_instr(1); do_instr(7);
      @(posedge clock); #1;
      exec_done = 1'b0; needs_mem = 1'b0;
      reset_n = 1'b0;
      mon_en = 1'b0;
      @(negedge clock);
      chk("in_mem_read", {62'd0, mem_req, mem_we}, {62'd0, 2'b10});
      @(posedge clock); #1; reset_n = 1'b1;
      @(negedge clock);
      chk("abort_load_valid", {63'd0, load_valid}, 64'd0);
      chk("abort_pc_count", {pc, instr_count}, 64'd0);
      chk("abort_mem_req", {63'd0, mem_req}, 64'd0);
      @(negedge clock);
      chk("abort_no_late_load", {63'd0, load_valid}, 64'd0);
      q_instr.delete(); q_load.delete(); q_wr.delete();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
